// File: rtl/seq_restoring_divider_if.sv
// ============================================================================
// Module   : seq_restoring_divider_if
// Brief    : Start/busy/done handshake and operand/result bundle for the divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_restoring_divider_if #(
    parameter int N_W = 8,
    parameter int D_W = 4
);
    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module   : seq_restoring_divider
// Brief    : Unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
    parameter int N_W = 8,
    parameter int D_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_restoring_divider_if.slave  bus
);
    localparam int c_CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state,     w_state;
    logic [c_CNT_W-1:0]   r_cnt,       w_cnt;
    logic [D_W:0]         r_rem,       w_rem;
    logic [N_W-1:0]       r_sh,        w_sh;
    logic [D_W-1:0]       r_divisor,   w_divisor;
    logic [N_W-1:0]       r_quotient,  w_quotient;
    logic [D_W-1:0]       r_remainder, w_remainder;
    logic                 r_dbz,       w_dbz;

    logic [D_W+1:0]       w_rem_sh;
    logic [D_W:0]         w_diff;
    logic                 w_qbit;
    logic [D_W:0]         w_rem_iter;
    logic [N_W-1:0]       w_sh_iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_sh        <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_rem       <= w_rem;
            r_sh        <= w_sh;
            r_divisor   <= w_divisor;
            r_quotient  <= w_quotient;
            r_remainder <= w_remainder;
            r_dbz       <= w_dbz;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_rem       = r_rem;
        w_sh        = r_sh;
        w_divisor   = r_divisor;
        w_quotient  = r_quotient;
        w_remainder = r_remainder;
        w_dbz       = r_dbz;

        // The partial remainder stays below the divisor, so the shifted value
        // fits comfortably in D_W+2 bits and the compare never wraps.
        w_rem_sh   = {r_rem, r_sh[N_W-1]};
        w_qbit     = (w_rem_sh >= {2'b00, r_divisor});
        w_diff     = w_rem_sh[D_W:0] - {1'b0, r_divisor};
        w_rem_iter = w_qbit ? w_diff : w_rem_sh[D_W:0];
        w_sh_iter  = {r_sh[N_W-2:0], w_qbit};

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_divisor = bus.divisor;
                    if (bus.divisor == '0) begin
                        w_state     = S_DONE;
                        w_quotient  = '1;
                        w_remainder = bus.dividend[D_W-1:0];
                        w_dbz       = 1'b1;
                    end else begin
                        w_state = S_CALC;
                        w_cnt   = c_CNT_W'(N_W - 1);
                        w_rem   = '0;
                        w_sh    = bus.dividend;
                    end
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_CALC: begin
                w_rem = w_rem_iter;
                w_sh  = w_sh_iter;
                if (r_cnt == '0) begin
                    w_state     = S_DONE;
                    w_quotient  = w_sh_iter;
                    w_remainder = w_rem_iter[D_W-1:0];
                    w_dbz       = 1'b0;
                end else begin
                    w_cnt = r_cnt - c_CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.busy        = (r_state == S_CALC);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module   : tb_seq_restoring_divider
// Brief    : Self-checking bench: vector table, exhaustive sweep, random ops, corners.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;
    localparam int N_W = 8;
    localparam int D_W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_restoring_divider_if #(.N_W(N_W), .D_W(D_W)) bus ();

    seq_restoring_divider #(.N_W(N_W), .D_W(D_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor saturates the quotient.
    task automatic model(input logic [7:0] n, input logic [3:0] d,
                         output logic [7:0] q, output logic [3:0] r, output logic dbz);
        if (d == 0) begin
            q = 8'hFF; r = n[3:0]; dbz = 1'b1;
        end else begin
            q = 8'(int'(n) / int'(d)); r = 4'(int'(n) % int'(d)); dbz = 1'b0;
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [7:0] n, input logic [3:0] d);
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_cnt, output logic timed_out);
        lat = 0; busy_cnt = 0; timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                          output int lat, output int busy_cnt, output logic timed_out);
        issue(n, d);
        wait_done(lat, busy_cnt, timed_out);
        if (timed_out) chk("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int         lat, bcnt, inv_err, done_seen;
        logic       to;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edbz;

        checks = 0; failures = 0;
        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        vecs[2] = '{8'd13,  4'd15, 8'd0,   4'd13, 1'b0};
        vecs[3] = '{8'd13,  4'd0,  8'hFF,  4'hD,  1'b1};
        vecs[4] = '{8'd100, 4'd9,  8'd11,  4'd1,  1'b0};
        vecs[5] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};

        rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_q",    32'(bus.quotient), 0);
        chk("reset_r",    32'(bus.remainder), 0);
        chk("reset_dbz",  32'(bus.div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].n, vecs[i].d, lat, bcnt, to);
            chk($sformatf("vec%0d_q", i),   32'(bus.quotient),    32'(vecs[i].q));
            chk($sformatf("vec%0d_r", i),   32'(bus.remainder),   32'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
            chk($sformatf("vec%0d_lat", i), 32'(lat),  vecs[i].dbz ? 32'd1 : 32'(N_W + 1));
            chk($sformatf("vec%0d_busy", i), 32'(bcnt), vecs[i].dbz ? 32'd0 : 32'(N_W));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 0);
            chk($sformatf("vec%0d_hold_q", i), 32'(bus.quotient), 32'(vecs[i].q));
        end

        // Exhaustive sweep, back-to-back on each done.
        inv_err = 0;
        for (int n = 0; n < 256; n++) begin
            for (int d = 1; d < 16; d++) begin
                run_op(8'(n), 4'(d), lat, bcnt, to);
                model(8'(n), 4'(d), eq, er, edbz);
                chk($sformatf("sweep_%0d_%0d", n, d), {20'd0, bus.quotient, bus.remainder}, {20'd0, eq, er});
                if ((int'(bus.quotient) * d + int'(bus.remainder) != n) || (int'(bus.remainder) >= d))
                    inv_err++;
            end
        end
        chk("sweep_invariant_errors", 32'(inv_err), 0);

        // Multiplier round trip.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a * b), 4'(b), lat, bcnt, to);
                chk($sformatf("rt_%0dx%0d", a, b), {20'd0, bus.quotient, bus.remainder}, {20'd0, 8'(a), 4'd0});
            end
        end

        // Random operands with random idle gaps, zero divisors included.
        for (int k = 0; k < 300; k++) begin
            logic [7:0] n;
            logic [3:0] d;
            n = 8'($urandom_range(0, 255));
            d = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(n, d, lat, bcnt, to);
            model(n, d, eq, er, edbz);
            chk($sformatf("rand_%0d_%0d", n, d),
                {19'd0, bus.quotient, bus.remainder, bus.div_by_zero}, {19'd0, eq, er, edbz});
            chk("rand_lat", 32'(lat), edbz ? 32'd1 : 32'(N_W + 1));
        end

        // start re-pulsed mid-CALC with other operands must be ignored.
        @(negedge clk);
        issue(8'd200, 4'd7);
        lat = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 3) begin bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3; end
            if (lat == 5) bus.start = 1'b0;
            if (bus.done) begin to = 1'b0; break; end
        end
        chk("interfere_timeout", 32'(to), 0);
        chk("interfere_lat", 32'(lat), 32'(N_W + 1));
        chk("interfere_q", 32'(bus.quotient), 28);
        chk("interfere_r", 32'(bus.remainder), 4);

        // Reset during CALC aborts without a done pulse.
        @(negedge clk);
        issue(8'd200, 4'd7);
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_q",    32'(bus.quotient), 0);
        chk("abort_r",    32'(bus.remainder), 0);
        chk("abort_dbz",  32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 0);
        run_op(8'd100, 4'd9, lat, bcnt, to);
        chk("post_abort_q",   32'(bus.quotient), 11);
        chk("post_abort_r",   32'(bus.remainder), 1);
        chk("post_abort_lat", 32'(lat), 32'(N_W + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential restoring divider, one quotient bit per clock. It is the inverse operation of the 4-bit array multipliers in the arithmetic test suite.
- Divides an N_W-bit dividend by a D_W-bit divisor and produces the quotient and remainder.
- Used as the companion unit for multiplier round-trip checks: (A*B)/B == A, remainder 0.
- Start/busy/done handshake, so it can sit behind a registered operand source.

Parameters:
- N_W, 8, dividend and quotient width.
- D_W, 4, divisor and remainder width; N_W >= D_W required.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled at a rising edge while in IDLE or DONE.
- dividend  input  N_W  numerator; captured when start is accepted.
- divisor  input  D_W  denominator; captured when start is accepted.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; results are valid.
- quotient  output  N_W  result; held until the next accepted start.
- remainder  output  D_W  result; held until the next accepted start.
- div_by_zero  output  1  set together with done when divisor == 0; held with the results.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal working registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge captures the operands.
  - If divisor!=0: go to CALC, load the bit counter with N_W-1, clear the partial remainder (D_W+1 bits), load the shift register with the dividend.
  - If divisor==0: go directly to DONE with quotient={N_W{1}}, remainder=dividend[D_W-1:0], div_by_zero=1.
- CALC, each cycle:
  - Shift {partial remainder, shift register} left by 1.
  - Trial-subtract the divisor from the partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After the iteration with counter==0, go to DONE and register quotient, remainder[D_W-1:0], div_by_zero=0.
  - busy=1 throughout CALC.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in this cycle is accepted, with the same rules as IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency:
  - Start accepted at edge E, nonzero divisor: busy high from after E through E+N_W; done high in the cycle following edge E+N_W. That is N_W+1 edges from acceptance to the done pulse.
  - Zero divisor: done high in the cycle after E, busy never asserted.
- start while busy=1 is ignored. Captured operands do not change mid-operation.
- Operand inputs are don't-care except at the accepting edge.
- Arithmetic:
  - Unsigned.
  - Invariant for divisor!=0: dividend == quotient*divisor + remainder, with remainder < divisor.
  - The partial remainder needs one guard bit (D_W+1) so the trial subtraction never overflows.
- Outputs quotient, remainder and div_by_zero change only at entry to DONE, or on reset.
- Reset asserted during CALC aborts the operation: no done pulse, outputs zeroed. The next start after deassertion behaves normally.

Test Plan:
- rst pulse, then start with dividend=200, divisor=7:
  - busy high for 8 cycles, then done pulse.
  - quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 → quotient=255, remainder=0.
- dividend=13, divisor=15 → quotient=0, remainder=13.
- dividend=13, divisor=0:
  - done in the next cycle, busy never high.
  - quotient=8'hFF, remainder=4'hD, div_by_zero=1.
- Exhaustive sweep, all 256 dividends × divisors 1..15, back-to-back start on each done:
  - Every result satisfies q*d+r==n and r<d; error count 0.
  - Round-trip sub-case: n=A*B for A,B in 0..15, B!=0 gives q==A, r==0.
- Interference and abort cases:
  - start re-pulsed with different operands mid-CALC: ignored, original result returned.
  - rst asserted at CALC cycle 4: outputs zero immediately, no done pulse.
  - Next start 100/9 → quotient=11, remainder=1.
